// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: command codes and field widths shared by the UART debug decoder and read arbiter.
package uart_pkg;
  parameter int CMDLENGTH = 8;
  parameter int IRLENGTH  = 8;

  parameter logic [CMDLENGTH-1:0] CMD_NOP       = 8'h00;
  parameter logic [CMDLENGTH-1:0] CMD_READ      = 8'h01;
  parameter logic [CMDLENGTH-1:0] CMD_CONT_READ = 8'h02;
  parameter logic [CMDLENGTH-1:0] CMD_RESET     = 8'h03;
endpackage
`default_nettype wire

// File: rtl/read_arbiter.sv
`default_nettype none
// read_arbiter: turns decoder read commands into register reads and streams the
// read value LSB-first as bytes to the UART transmitter; supports continuous read.
module read_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 41
) (
  input  logic                  CLK_I,
  input  logic                  RST_NI,
  input  logic [CMDLENGTH-1:0]  COMMAND_I,
  input  logic [IRLENGTH-1:0]   ADDRESS_I,
  input  logic                  VALID_I,
  output logic                  READY_O,
  output logic                  REG_REQ_O,
  output logic [IRLENGTH-1:0]   REG_ADDR_O,
  input  logic                  REG_ACK_I,
  input  logic [DATA_WIDTH-1:0] REG_DATA_I,
  output logic [7:0]            TX_DATA_O,
  output logic                  TX_VALID_O,
  input  logic                  TX_READY_I,
  output logic                  DTM_RESET_O
);

  localparam int NBYTES = (DATA_WIDTH + 7) / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2,
    ST_CONT = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [IRLENGTH-1:0]     addr_q, addr_d;
  logic [NBYTES*8-1:0]     data_q, data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    cont_q, cont_d;
  logic                    dtm_reset_q, dtm_reset_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    cont_d      = cont_q;
    dtm_reset_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_CONT: begin
        if (VALID_I) begin
          // A command in ST_CONT ends the repeat loop and is handled as from idle.
          case (COMMAND_I)
            CMD_READ, CMD_CONT_READ: begin
              addr_d  = ADDRESS_I;
              cont_d  = (COMMAND_I == CMD_CONT_READ);
              state_d = ST_REQ;
            end
            CMD_RESET: begin
              addr_d      = '0;
              data_d      = '0;
              cnt_d       = '0;
              cont_d      = 1'b0;
              dtm_reset_d = 1'b1;
              state_d     = ST_IDLE;
            end
            default: begin
              cont_d  = 1'b0;
              state_d = ST_IDLE;
            end
          endcase
        end else if (state_q == ST_CONT) begin
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (REG_ACK_I) begin
          data_d                 = '0;
          data_d[DATA_WIDTH-1:0] = REG_DATA_I;
          cnt_d                  = '0;
          state_d                = ST_SEND;
        end
      end

      ST_SEND: begin
        if (TX_READY_I) begin
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            state_d = cont_q ? ST_CONT : ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      cont_q      <= 1'b0;
      dtm_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      cont_q      <= cont_d;
      dtm_reset_q <= dtm_reset_d;
    end
  end

  // Outputs decode only the state register, so REG_REQ_O and TX_VALID_O are exclusive.
  assign READY_O     = (state_q == ST_IDLE) || (state_q == ST_CONT);
  assign REG_REQ_O   = (state_q == ST_REQ);
  assign REG_ADDR_O  = addr_q;
  assign TX_VALID_O  = (state_q == ST_SEND);
  assign TX_DATA_O   = TX_VALID_O ? data_q[{cnt_q, 3'b000} +: 8] : 8'h00;
  assign DTM_RESET_O = dtm_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_read_arbiter.sv
`default_nettype none
// tb_read_arbiter: randomized read traffic against a byte-queue reference model.
module tb_read_arbiter;
  import uart_pkg::*;

  localparam int DW = 41;
  localparam int NB = (DW + 7) / 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [CMDLENGTH-1:0] COMMAND_I;
  logic [IRLENGTH-1:0]  ADDRESS_I;
  logic                 VALID_I;
  logic                 READY_O;
  logic                 REG_REQ_O;
  logic [IRLENGTH-1:0]  REG_ADDR_O;
  logic                 REG_ACK_I;
  logic [DW-1:0]        REG_DATA_I;
  logic [7:0]           TX_DATA_O;
  logic                 TX_VALID_O;
  logic                 TX_READY_I;
  logic                 DTM_RESET_O;

  logic resp_ack, spur_ack;
  assign REG_ACK_I = resp_ack | spur_ack;

  always #5 clk = ~clk;

  read_arbiter #(.DATA_WIDTH(DW)) dut (
    .CLK_I(clk), .RST_NI(rst_n), .COMMAND_I(COMMAND_I), .ADDRESS_I(ADDRESS_I),
    .VALID_I(VALID_I), .READY_O(READY_O), .REG_REQ_O(REG_REQ_O), .REG_ADDR_O(REG_ADDR_O),
    .REG_ACK_I(REG_ACK_I), .REG_DATA_I(REG_DATA_I), .TX_DATA_O(TX_DATA_O),
    .TX_VALID_O(TX_VALID_O), .TX_READY_I(TX_READY_I), .DTM_RESET_O(DTM_RESET_O)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected byte stream and register addresses.
  logic [7:0]    exp_b[$], got_b[$];
  int            got_cyc[$];
  logic [7:0]    exp_a[$], got_a[$];
  logic [DW-1:0] rd_q[$];

  int cyc = 0;
  int tx_mode = 0;
  int overlap = 0, req_cycles = 0, dtm_cycles = 0;

  always @(posedge clk) cyc++;

  // Monitor: captures accepted bytes and checks hold/exclusivity.
  initial begin
    logic       prev_v, prev_r;
    logic [7:0] prev_d;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'h00;
    forever begin
      @(negedge clk);
      if (prev_v && !prev_r && TX_VALID_O) chk("hold", 64'(TX_DATA_O), 64'(prev_d));
      if (TX_VALID_O && TX_READY_I) begin
        got_b.push_back(TX_DATA_O);
        got_cyc.push_back(cyc);
      end
      if (REG_REQ_O && TX_VALID_O) overlap++;
      if (REG_REQ_O) req_cycles++;
      if (DTM_RESET_O) dtm_cycles++;
      prev_v = TX_VALID_O; prev_r = TX_READY_I; prev_d = TX_DATA_O;
    end
  end

  // Transmitter ready: always / toggling / random.
  initial begin
    TX_READY_I = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tx_mode)
        0:       TX_READY_I = 1'b1;
        1:       TX_READY_I = ~TX_READY_I;
        default: TX_READY_I = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Register responder: acknowledges requests after a random delay.
  initial begin
    resp_ack   = 1'b0;
    REG_DATA_I = '0;
    forever begin
      @(negedge clk);
      if (resp_ack) begin
        resp_ack   = 1'b0;
        REG_DATA_I = DW'({$urandom(), $urandom()});
      end else if (REG_REQ_O && rd_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        got_a.push_back(REG_ADDR_O);
        REG_DATA_I = rd_q.pop_front();
        resp_ack   = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [7:0] cmd, input logic [7:0] a);
    int t = 0;
    while (!READY_O && t < 300) begin tick(1); t++; end
    if (t >= 300) chk("ready_timeout", 64'(READY_O), 64'd1);
    VALID_I = 1'b1; COMMAND_I = cmd; ADDRESS_I = a;
    tick(1);
    VALID_I = 1'b0; COMMAND_I = 8'($urandom()); ADDRESS_I = 8'($urandom());
  endtask

  task automatic model_frame(input logic [7:0] a, input logic [DW-1:0] d, input int nbytes);
    logic [NB*8-1:0] ext;
    ext = (NB*8)'(d);
    exp_a.push_back(a);
    rd_q.push_back(d);
    for (int i = 0; i < nbytes; i++) exp_b.push_back(8'((ext >> (8 * i)) & 'hFF));
  endtask

  task automatic read(input logic [7:0] a, input logic [DW-1:0] d);
    model_frame(a, d, NB);
    issue(CMD_READ, a);
    chk("busy_after_accept", 64'(READY_O), 64'd0);
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while (got_b.size() < n && t < 1000) begin tick(1); t++; end
    if (t >= 1000) chk("bytes_timeout", 64'(got_b.size()), 64'(n));
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(READY_O && got_b.size() >= exp_b.size()) && t < 1000) begin tick(1); t++; end
    if (t >= 1000) chk("idle_timeout", 64'(got_b.size()), 64'(exp_b.size()));
    tick(1);
  endtask

  initial begin
    int base, rq, d0;
    VALID_I = 1'b0; COMMAND_I = '0; ADDRESS_I = '0; spur_ack = 1'b0;
    rst_n = 1'b0;
    tick(2);
    chk("rst_req", 64'(REG_REQ_O), 64'd0);
    chk("rst_addr", 64'(REG_ADDR_O), 64'd0);
    chk("rst_txv", 64'(TX_VALID_O), 64'd0);
    chk("rst_txd", 64'(TX_DATA_O), 64'd0);
    chk("rst_dtm", 64'(DTM_RESET_O), 64'd0);
    rst_n = 1'b1;
    tick(1);
    chk("rst_ready", 64'(READY_O), 64'd1);

    // Spurious ack while idle must be ignored.
    tx_mode = 0;
    spur_ack = 1'b1; tick(1); spur_ack = 1'b0; tick(1);
    chk("spur_ready", 64'(READY_O), 64'd1);
    chk("spur_txv", 64'(TX_VALID_O), 64'd0);
    read(8'h22, DW'(8'hAA));
    wait_idle();
    chk("spur_first_byte", 64'(got_b[0]), 64'hAA);

    // Full-rate read of the reference value.
    base = got_b.size();
    read(8'h11, 41'h1_2345_6789A);
    wait_idle();
    chk("consecutive_bytes", 64'(got_cyc[base+NB-1] - got_cyc[base]), 64'(NB - 1));
    chk("ready_after_read", 64'(READY_O), 64'd1);

    // Same read under a toggling transmitter.
    tx_mode = 1;
    read(8'h11, 41'h1_2345_6789A);
    wait_idle();

    // Continuous read: two frames, then NOP stops it.
    tx_mode = 0;
    base = got_b.size();
    model_frame(8'h01, DW'(5), NB);
    model_frame(8'h01, DW'(6), NB);
    issue(CMD_CONT_READ, 8'h01);
    wait_bytes(base + 2 * NB);
    issue(CMD_NOP, 8'h00);
    rq = req_cycles;
    tick(20);
    chk("cont_no_more_req", 64'(req_cycles), 64'(rq));
    chk("cont_ready", 64'(READY_O), 64'd1);
    chk("cont_acks", 64'(got_a.size()), 64'(exp_a.size()));

    // Reset command: one-cycle pulse, registers cleared.
    d0 = dtm_cycles;
    base = got_b.size();
    issue(CMD_RESET, 8'h00);
    chk("dtm_pulse", 64'(DTM_RESET_O), 64'd1);
    chk("dtm_ready", 64'(READY_O), 64'd1);
    chk("dtm_addr_clr", 64'(REG_ADDR_O), 64'd0);
    tick(1);
    chk("dtm_pulse_end", 64'(DTM_RESET_O), 64'd0);
    tick(3);
    chk("dtm_width", 64'(dtm_cycles - d0), 64'd1);
    chk("dtm_no_tx", 64'(got_b.size()), 64'(base));

    // Asynchronous reset after the third byte abandons the frame.
    base = got_b.size();
    model_frame(8'h33, 41'h0AB_CDEF_0123, 3);
    issue(CMD_READ, 8'h33);
    wait_bytes(base + 3);
    rst_n = 1'b0;
    #1;
    chk("async_txv", 64'(TX_VALID_O), 64'd0);
    chk("async_txd", 64'(TX_DATA_O), 64'd0);
    chk("async_addr", 64'(REG_ADDR_O), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    chk("abandon_bytes", 64'(got_b.size()), 64'(base + 3));
    chk("abandon_ready", 64'(READY_O), 64'd1);

    // Randomized mix of reads and other commands.
    tx_mode = 2;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        read(8'($urandom()), DW'({$urandom(), $urandom()}));
        wait_idle();
      end else begin
        logic [7:0] c;
        c = ($urandom_range(0, 1) == 1) ? CMD_NOP : 8'($urandom_range(4, 255));
        issue(c, 8'($urandom()));
        chk("other_cmd_ready", 64'(READY_O), 64'd1);
        chk("other_cmd_noreq", 64'(REG_REQ_O), 64'd0);
      end
    end
    tick(5);

    chk("byte_count", 64'(got_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      chk($sformatf("byte[%0d]", i), 64'(got_b[i]), 64'(exp_b[i]));
    chk("addr_count", 64'(got_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      chk($sformatf("addr[%0d]", i), 64'(got_a[i]), 64'(exp_a[i]));
    chk("req_tx_overlap", 64'(overlap), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
